// File: rtl/cache_arbiter_pkg.sv
// Shared types for the icache/dcache to cacheline-adaptor arbiter.
// Holds the FSM state encoding, the requester identity and the grant rule.
package arbiter_types;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      DONE
   } arb_state_t;

   typedef enum logic {
      I = 1'b0,
      D = 1'b1
   } requester_t;

   // On a tie the requester not served last time wins.
   function automatic arb_state_t pick_grant(
      input logic       req_i,
      input logic       req_d,
      input requester_t last
   );
      arb_state_t s;
      s = IDLE;
      if (req_i && req_d) begin
         s = (last == I) ? SERVE_D : SERVE_I;
      end else if (req_i) begin
         s = SERVE_I;
      end else if (req_d) begin
         s = SERVE_D;
      end
      return s;
   endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between icache and dcache line traffic.
// One transaction at a time is forwarded to the cacheline adaptor.
import arbiter_types::*;

module cache_arbiter (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_mem_read,
   input  logic [ADDR_W-1:0]  i_mem_address,
   output logic [LINE_W-1:0]  i_mem_rdata,
   output logic               i_mem_resp,
   input  logic               d_mem_read,
   input  logic               d_mem_write,
   input  logic [ADDR_W-1:0]  d_mem_address,
   input  logic [LINE_W-1:0]  d_mem_wdata,
   output logic [LINE_W-1:0]  d_mem_rdata,
   output logic               d_mem_resp,
   output logic               ca_read,
   output logic               ca_write,
   output logic [ADDR_W-1:0]  ca_address,
   output logic [LINE_W-1:0]  ca_wdata,
   input  logic [LINE_W-1:0]  ca_rdata,
   input  logic               ca_resp
);

   arb_state_t           r_state;
   arb_state_t           w_next;
   requester_t           r_last;
   logic [ADDR_W-1:0]    r_addr;
   logic [LINE_W-1:0]    r_wdata;
   logic                 r_write;

   logic                 w_req_i;
   logic                 w_req_d;
   logic                 w_grant;
   logic                 w_grant_d;
   logic                 w_serve;

   assign w_req_i = i_mem_read;
   assign w_req_d = d_mem_read | d_mem_write;

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            w_next    = pick_grant(w_req_i, w_req_d, r_last);
            w_grant   = (w_next != IDLE);
            w_grant_d = (w_next == SERVE_D);
         end
         SERVE_I, SERVE_D: begin
            if (ca_resp) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= I;
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_last  <= w_grant_d ? D : I;
            r_addr  <= w_grant_d ? d_mem_address : i_mem_address;
            r_wdata <= w_grant_d ? d_mem_wdata : '0;
            // A dcache asserting both read and write is treated as a write.
            r_write <= w_grant_d & d_mem_write;
         end
      end
   end

   assign w_serve = ~rst
                  & ((r_state == SERVE_I) | (r_state == SERVE_D));

   assign ca_read    = w_serve & ~r_write;
   assign ca_write   = w_serve & r_write;
   assign ca_address = r_addr;
   assign ca_wdata   = r_wdata;

   assign i_mem_resp = ~rst & (r_state == SERVE_I) & ca_resp;
   assign d_mem_resp = ~rst & (r_state == SERVE_D) & ca_resp;

   assign i_mem_rdata = ca_rdata;
   assign d_mem_rdata = ca_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized and directed bench for cache_arbiter against a
// transaction-level ownership model.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_mem_read;
   logic [31:0]  i_mem_address;
   logic [255:0] i_mem_rdata;
   logic         i_mem_resp;
   logic         d_mem_read;
   logic         d_mem_write;
   logic [31:0]  d_mem_address;
   logic [255:0] d_mem_wdata;
   logic [255:0] d_mem_rdata;
   logic         d_mem_resp;
   logic         ca_read;
   logic         ca_write;
   logic [31:0]  ca_address;
   logic [255:0] ca_wdata;
   logic [255:0] ca_rdata;
   logic         ca_resp;

   int errs = 0;
   int checks = 0;

   // owner: 0 = adaptor free, 1 = icache, 2 = dcache
   int           m_owner;
   bit           m_gap;
   int           m_last;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata;
   bit           m_wr;
   int           dut_order[$];

   always #5 clk = ~clk;

   cache_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .i_mem_read    (i_mem_read),
      .i_mem_address (i_mem_address),
      .i_mem_rdata   (i_mem_rdata),
      .i_mem_resp    (i_mem_resp),
      .d_mem_read    (d_mem_read),
      .d_mem_write   (d_mem_write),
      .d_mem_address (d_mem_address),
      .d_mem_wdata   (d_mem_wdata),
      .d_mem_rdata   (d_mem_rdata),
      .d_mem_resp    (d_mem_resp),
      .ca_read       (ca_read),
      .ca_write      (ca_write),
      .ca_address    (ca_address),
      .ca_wdata      (ca_wdata),
      .ca_rdata      (ca_rdata),
      .ca_resp       (ca_resp)
   );

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic quiet();
      rst           = 1'b0;
      i_mem_read    = 1'b0;
      d_mem_read    = 1'b0;
      d_mem_write   = 1'b0;
      ca_resp       = 1'b0;
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_gap   = 1'b0;
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
      m_wr    = 1'b0;
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge();
      int pick;
      bit wi;
      bit wd;
      if (rst) begin
         model_reset();
      end else if (m_owner != 0) begin
         if (ca_resp) begin
            m_owner = 0;
            m_gap   = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else begin
         wi = i_mem_read;
         wd = d_mem_read | d_mem_write;
         pick = 0;
         if (wi && wd) pick = (m_last == 1) ? 2 : 1;
         else if (wi) pick = 1;
         else if (wd) pick = 2;
         if (pick != 0) begin
            m_owner = pick;
            m_last  = pick;
            m_addr  = (pick == 1) ? i_mem_address : d_mem_address;
            m_wdata = (pick == 1) ? '0 : d_mem_wdata;
            m_wr    = (pick == 2) && d_mem_write;
         end
      end
   endtask

   // Compare every output with the model, then take one clock.
   task automatic step();
      bit busy;
      #1;
      busy = !rst && (m_owner != 0);
      check("ca_read", ca_read, busy && !m_wr);
      check("ca_write", ca_write, busy && m_wr);
      check("ca_excl", ca_read & ca_write, 1'b0);
      check("ca_address", ca_address, m_addr);
      check("ca_wdata", ca_wdata, m_wdata);
      check("i_resp", i_mem_resp, busy && m_owner == 1 && ca_resp);
      check("d_resp", d_mem_resp, busy && m_owner == 2 && ca_resp);
      check("i_rdata", i_mem_rdata, ca_rdata);
      check("d_rdata", d_mem_rdata, ca_rdata);
      if (d_mem_resp) dut_order.push_back(2);
      if (i_mem_resp) dut_order.push_back(1);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [255:0] a5;
      int waitc;
      quiet();
      i_mem_address = '0;
      d_mem_address = '0;
      d_mem_wdata   = '0;
      ca_rdata      = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;

      #1;
      check("rst_read", ca_read, 1'b0);
      check("rst_write", ca_write, 1'b0);
      check("rst_addr", ca_address, 32'h0);
      check("rst_iresp", i_mem_resp, 1'b0);
      check("rst_dresp", d_mem_resp, 1'b0);

      // Icache only, adaptor answers after five serve cycles.
      a5 = {32{8'hA5}};
      i_mem_read = 1'b1;
      i_mem_address = 32'h60;
      step();
      for (int k = 0; k < 4; k++) begin
         #1;
         check("ionly_read", ca_read, 1'b1);
         check("ionly_addr", ca_address, 32'h60);
         step();
      end
      ca_resp = 1'b1;
      ca_rdata = a5;
      #1;
      check("ionly_resp", i_mem_resp, 1'b1);
      check("ionly_data", i_mem_rdata, a5);
      check("ionly_dresp", d_mem_resp, 1'b0);
      step();
      quiet();
      #1;
      check("ionly_done", ca_read, 1'b0);
      step();
      step();

      // Simultaneous after reset: dcache write wins the tie.
      do_reset();
      i_mem_read = 1'b1;
      i_mem_address = 32'h100;
      d_mem_write = 1'b1;
      d_mem_address = 32'h200;
      d_mem_wdata = {8{32'hDEADBEEF}};
      step();
      #1;
      check("tie_write", ca_write, 1'b1);
      check("tie_addr", ca_address, 32'h200);
      ca_resp = 1'b1;
      step();
      d_mem_write = 1'b0;
      ca_resp = 1'b0;
      step();
      step();
      #1;
      check("tie2_read", ca_read, 1'b1);
      check("tie2_addr", ca_address, 32'h100);
      ca_resp = 1'b1;
      step();
      quiet();
      step();
      step();

      // Back-to-back contention: grants alternate D, I, D, I.
      do_reset();
      dut_order.delete();
      i_mem_read = 1'b1;
      d_mem_read = 1'b1;
      waitc = 0;
      while (dut_order.size() < 4 && waitc < 40) begin
         ca_resp = ((waitc % 4) == 2);
         step();
         waitc++;
      end
      check("b2b_count", dut_order.size(), 4);
      for (int k = 0; k < 4 && k < dut_order.size(); k++) begin
         check("b2b_order", dut_order[k], (k % 2 == 0) ? 2 : 1);
      end
      quiet();
      step();
      step();

      // Dcache address changes mid-service.
      d_mem_read = 1'b1;
      d_mem_address = 32'h300;
      step();
      d_mem_address = 32'h400;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold_addr", ca_address, 32'h300);
         step();
      end
      ca_resp = 1'b1;
      step();
      quiet();
      step();
      step();

      // Reset during an icache read, then a tie goes to dcache.
      i_mem_read = 1'b1;
      i_mem_address = 32'h780;
      step();
      #1;
      check("mid_read", ca_read, 1'b1);
      rst = 1'b1;
      step();
      quiet();
      #1;
      check("mid_rd_after", ca_read, 1'b0);
      ca_resp = 1'b1;
      #1;
      check("mid_noresp", i_mem_resp, 1'b0);
      step();
      ca_resp = 1'b0;
      i_mem_read = 1'b1;
      d_mem_read = 1'b1;
      d_mem_address = 32'h9E0;
      step();
      #1;
      check("mid_tie_addr", ca_address, 32'h9E0);
      check("mid_tie_read", ca_read, 1'b1);
      ca_resp = 1'b1;
      step();
      quiet();
      step();
      step();

      // Dcache raising read and write together is a write.
      d_mem_read = 1'b1;
      d_mem_write = 1'b1;
      d_mem_address = 32'hA40;
      step();
      #1;
      check("both_write", ca_write, 1'b1);
      check("both_read", ca_read, 1'b0);
      ca_resp = 1'b1;
      step();
      quiet();
      step();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 99) == 0);
         i_mem_read    = $urandom_range(0, 1);
         d_mem_read    = $urandom_range(0, 1);
         d_mem_write   = ($urandom_range(0, 2) == 0);
         i_mem_address = {$urandom(), 5'b0} & 32'hFFFF_FFE0;
         d_mem_address = {$urandom(), 5'b0} & 32'hFFFF_FFE0;
         d_mem_wdata   = {8{$urandom()}};
         ca_rdata      = {8{$urandom()}};
         ca_resp       = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- i_mem_read, in, 1: icache line-fill request.
- i_mem_address, in, 32: icache line address, 32-byte aligned.
- i_mem_rdata, out, 256: line returned to the icache.
- i_mem_resp, out, 1: icache transaction complete.
- d_mem_read, in, 1: dcache line-fill request.
- d_mem_write, in, 1: dcache writeback request.
- d_mem_address, in, 32: dcache line address.
- d_mem_wdata, in, 256: dcache writeback line.
- d_mem_rdata, out, 256: line returned to the dcache.
- d_mem_resp, out, 1: dcache transaction complete.
- ca_read, out, 1: line read to the cacheline adaptor.
- ca_write, out, 1: line write to the cacheline adaptor.
- ca_address, out, 32: line address to the adaptor.
- ca_wdata, out, 256: write line to the adaptor.
- ca_rdata, in, 256: read line from the adaptor.
- ca_resp, in, 1: adaptor transaction complete.

Function
REQ-003 The block SHALL be an FSM with states IDLE, SERVE_I, SERVE_D and DONE.
REQ-004 In IDLE, the grant SHALL be decided as follows:
- Only i_mem_read high: go to SERVE_I.
- Only d_mem_read or d_mem_write high: go to SERVE_D.
- Both requesters high: grant the requester not named in last_grant.
- No request: remain in IDLE.
REQ-005 On the grant edge, the block SHALL latch address, wdata and direction into registers, and SHALL set last_grant to the granted requester.
REQ-006 If d_mem_read and d_mem_write are both high, the block SHALL latch a write.
REQ-007 In SERVE_I and SERVE_D, ca_read or ca_write SHALL be driven high continuously from the latched direction until ca_resp.
- ca_address and ca_wdata SHALL be driven from the latched registers.
- Requester input changes during service SHALL be ignored.
REQ-008 Latency: a request sampled in IDLE at edge N SHALL produce ca_read or ca_write high in the cycle after N.
REQ-009 When ca_resp is high in SERVE_x, the granted requester's resp SHALL be high in that same cycle (combinational), and the FSM SHALL go to DONE.
REQ-010 The non-granted requester's resp SHALL remain 0 at all times outside its own service.
REQ-011 DONE SHALL last exactly one cycle with ca_read and ca_write low, then go to IDLE unconditionally; no same-cycle re-grant is allowed.
REQ-012 i_mem_rdata and d_mem_rdata SHALL both equal ca_rdata combinationally; only resp qualifies the data.
REQ-013 A ca_resp received in IDLE or DONE SHALL be ignored: no requester resp and no state change.
REQ-014 The block SHALL never assert ca_read and ca_write simultaneously.
REQ-015 Round-robin SHALL bound wait time: a continuously requesting cache is granted within one other transaction.

Reset
REQ-016 On rst high at a clock edge, the block SHALL set the following, including mid-transaction:
- state = IDLE;
- last_grant = I, so the first tie goes to the dcache;
- latched address and wdata = 0.
REQ-017 During and after reset, ca_read, ca_write, i_mem_resp and d_mem_resp SHALL be 0 until a new grant or response.

Structure
REQ-018 The arb_state_t enum and the requester enum (I, D) used for last_grant SHALL live in the shared package arbiter_types.
REQ-019 The block SHALL have no sub-module; it SHALL be one FSM with latch registers, sitting between the two caches and the cacheline adaptor inside mp4.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Icache only: i_mem_read=1 with address 0x00000060, adaptor responds 5 cycles later with rdata=A5..A5 -> ca_read=1 with ca_address 0x00000060; i_mem_resp=1 for one cycle; d_mem_resp=0 throughout.
- Simultaneous after reset: i_mem_read=1 (0x100) and d_mem_write=1 (0x200) in the same cycle -> dcache served first (ca_write, 0x200), then DONE, IDLE, then icache (ca_read, 0x100).
- Back-to-back contention: both caches requesting continuously for 4 transactions -> grant order D, I, D, I, each separated by a DONE cycle.
- Input change mid-service: d_mem_address changes from 0x300 to 0x400 during SERVE_D -> ca_address stays 0x300 until ca_resp.
- Reset mid-transaction: rst asserted while ca_read=1 -> next cycle ca_read=0, state IDLE, no resp; a subsequent tie grants D.
- Illegal both-high: d_mem_read=d_mem_write=1 -> ca_write=1, ca_read=0, never both high.
